// File: rtl/booth_mul_seq_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier.
// FSM states and Booth digit select encodings.
package booth_mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    D_ZERO = 3'd0,
    D_P1   = 3'd1,
    D_P2   = 3'd2,
    D_M1   = 3'd3,
    D_M2   = 3'd4
  } digit_e;

endpackage

// File: rtl/booth_mul_seq_enc.sv
// Radix-4 Booth encoder: 3-bit multiplier window
// to {neg, two, zero} partial-product controls.
module booth_enc
  import booth_mul_seq_pkg::*;
(
  input  logic [2:0] win,
  output logic       neg,
  output logic       two,
  output logic       zero
);

  digit_e dig;

  always_comb begin
    dig = D_ZERO;
    unique case (win)
      3'b001, 3'b010: dig = D_P1;
      3'b011:         dig = D_P2;
      3'b100:         dig = D_M2;
      3'b101, 3'b110: dig = D_M1;
      default:        dig = D_ZERO;
    endcase
    neg  = (dig == D_M1) || (dig == D_M2);
    two  = (dig == D_P2) || (dig == D_M2);
    zero = (dig == D_ZERO);
  end

endmodule

// File: rtl/cla_4b.sv
// 4-bit carry-lookahead adder slice.
// Chained per nibble to build wider adders.
module cla_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, one digit per cycle,
// accumulating through a ripple chain of cla_4b slices.
module booth_mul_seq
  import booth_mul_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW  = 2 * WIDTH;
  localparam int N   = WIDTH / 2;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int NIB = PW / 4;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   prod_q, prod_d;

  logic [WIDTH:0]  bx;
  logic [2:0]      win;
  logic            neg, two, zero;
  logic [PW-1:0]   ax, mag, sh, pp;
  logic [PW-1:0]   sum;
  logic [NIB:0]    c;
  logic            carry_unused;

  // bx[0] supplies the implicit b[-1] = 0 of digit 0
  always_comb begin
    bx  = {b_q, 1'b0};
    win = 3'(bx >> {cnt_q, 1'b0});
  end

  booth_enc u_enc (
    .win  (win),
    .neg  (neg),
    .two  (two),
    .zero (zero)
  );

  always_comb begin
    ax  = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    mag = zero ? '0 : (two ? (ax << 1) : ax);
    sh  = mag << {cnt_q, 1'b0};
    pp  = neg ? ~sh : sh;
  end

  assign c[0] = neg;

  for (genvar g = 0; g < NIB; g++) begin : g_cla
    cla_4b u_cla (
      .a    (acc_q[4*g +: 4]),
      .b    (pp[4*g +: 4]),
      .cin  (c[g]),
      .sum  (sum[4*g +: 4]),
      .cout (c[g+1])
    );
  end

  assign carry_unused = c[NIB];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          prod_d  = sum;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq (WIDTH=8):
// directed corners, random sweep, reset abort, back-to-back.
module tb_booth_mul_seq;

  localparam int W = 8;
  localparam int N = W / 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  function automatic logic [2*W-1:0] ref_mul(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    int xi;
    int yi;
    int p;
    xi = $signed(x);
    yi = $signed(y);
    p  = xi * yi;
    return p[2*W-1:0];
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  bit             hold,
    input  bit             scram,
    output logic [2*W-1:0] res,
    output int             lat,
    output int             bsy,
    output int             ndone
  );
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    lat   = -1;
    bsy   = 0;
    ndone = 0;
    res   = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (scram) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      if (busy) bsy++;
      if (done) begin
        ndone++;
        if (lat < 0) lat = i;
        res = product;
      end
      if (!busy) break;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t dir[5] = '{
    '{8'd3,   8'd5,   16'h000F},
    '{8'h80,  8'h80,  16'h4000},
    '{8'h7F,  8'h80,  16'hC080},
    '{8'h5A,  8'h00,  16'h0000},
    '{8'hFF,  8'hFF,  16'h0001}
  };

  initial begin
    logic [2*W-1:0] res;
    logic [2*W-1:0] q[$];
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    int lat;
    int bsy;
    int nd;
    int got;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prod", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (dir[i]) begin
      run_op(dir[i].x, dir[i].y, 1'b0, 1'b0,
             res, lat, bsy, nd);
      chk($sformatf("dir%0d_prod", i), 32'(res), 32'(dir[i].p));
      chk($sformatf("dir%0d_lat", i), 32'(lat), 32'(N + 1));
      chk($sformatf("dir%0d_busy", i), 32'(bsy), 32'(N + 1));
      chk($sformatf("dir%0d_ndone", i), 32'(nd), 32'd1);
    end

    repeat (3) @(negedge clk);
    chk("hold_prod", 32'(product), 32'(dir[4].p));

    run_op(8'd100, 8'hE7, 1'b1, 1'b1, res, lat, bsy, nd);
    chk("busy_start_ndone", 32'(nd), 32'd1);
    chk("scram_prod", 32'(res), 32'(ref_mul(8'd100, 8'hE7)));
    chk("scram_lat", 32'(lat), 32'(N + 1));

    @(negedge clk);
    a     = 8'd9;
    b     = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_prod", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd  = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_nodone", 32'(nd), 32'd0);
    run_op(8'd7, 8'hFD, 1'b0, 1'b0, res, lat, bsy, nd);
    chk("post_abort_prod", 32'(res), 32'h0000FFEB);

    for (int i = 0; i < 1000; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      run_op(x, y, 1'b0, 1'b0, res, lat, bsy, nd);
      chk($sformatf("rand%0d_%0h_%0h", i, x, y),
          32'(res), 32'(ref_mul(x, y)));
    end

    got = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        got++;
        if (q.size() == 0) chk("b2b_extra", 32'd1, 32'd0);
        else chk($sformatf("b2b%0d_prod", got),
                 32'(product), 32'(q.pop_front()));
      end
      a = W'($urandom);
      b = W'($urandom);
      if (!busy) q.push_back(ref_mul(a, b));
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        got++;
        if (q.size() == 0) chk("b2b_extra", 32'd1, 32'd0);
        else chk($sformatf("b2b%0d_prod", got),
                 32'(product), 32'(q.pop_front()));
      end
      @(negedge clk);
    end
    chk("b2b_pending", 32'(q.size()), 32'd0);
    chk("b2b_min_done", 32'(got >= 5), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
